// File: rtl/pipe_pkg.sv
// Shared pipeline constants and types for the 5-stage core front end.
// Imported by the IF stage and its IF/ID pipeline register.
package pipe_pkg;

   localparam int          XLEN      = 32;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// Generic IF/ID pipeline register: valid/pc/pc4/instr with flush > hold > load.
// A flush inserts a bubble (valid low, NOP); pc/pc4 keep their last values.
module if_id_reg #(
   parameter int                XLEN      = pipe_pkg::XLEN,
   parameter logic [31:0]       NOP_INSTR = pipe_pkg::NOP_INSTR
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            flush_i,
   input  logic            hold_i,
   input  logic            load_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [31:0]     instr_i,
   output logic            valid_o,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] pc4_o,
   output logic [31:0]     instr_o
);

   localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

   // Pipeline register update with flush > hold > load priority.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         valid_o <= 1'b0;
         pc_o    <= {XLEN{1'b0}};
         pc4_o   <= PC_STEP;
         instr_o <= NOP_INSTR;
      end else if (flush_i) begin
         valid_o <= 1'b0;
         instr_o <= NOP_INSTR;
      end else if (hold_i) begin
         valid_o <= valid_o;
      end else if (load_i) begin
         valid_o <= 1'b1;
         pc_o    <= pc_i;
         pc4_o   <= pc_i + PC_STEP;
         instr_o <= instr_i;
      end else begin
         valid_o <= valid_o;
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, req/ack fetch FSM, one-word skid buffer and IF/ID register.
// Redirects from EX take priority over hazard stalls and memory acks.
module if_stage #(
   parameter int                XLEN      = pipe_pkg::XLEN,
   parameter logic [XLEN-1:0]   RESET_PC  = pipe_pkg::RESET_PC,
   parameter logic [31:0]       NOP_INSTR = pipe_pkg::NOP_INSTR
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            hazard_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_ack_i,
   input  logic [31:0]     imem_rdata_i,
   output logic            if_id_valid_o,
   output logic [XLEN-1:0] if_id_pc_o,
   output logic [XLEN-1:0] if_id_pc4_o,
   output logic [31:0]     if_id_instr_o
);

   import pipe_pkg::*;

   localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

   fetch_state_t    state_r;
   fetch_state_t    state_nxt_s;
   logic [XLEN-1:0] pc_r;
   logic [XLEN-1:0] pc_nxt_s;
   logic [31:0]     buf_r;
   logic [31:0]     buf_nxt_s;
   logic            req_r;
   logic [XLEN-1:0] addr_r;
   logic            ifid_flush_s;
   logic            ifid_hold_s;
   logic            ifid_load_s;
   logic [31:0]     ifid_instr_s;
   logic [XLEN-1:0] redirect_tgt_s;

   assign redirect_tgt_s = word_align(redirect_pc_i);

   // Next-state, next-PC, skid buffer and IF/ID control decode.
   always_comb begin
      state_nxt_s  = state_r;
      pc_nxt_s     = pc_r;
      buf_nxt_s    = buf_r;
      ifid_flush_s = 1'b0;
      ifid_hold_s  = 1'b0;
      ifid_load_s  = 1'b0;
      ifid_instr_s = imem_rdata_i;
      case (state_r)
         IDLE: begin
            state_nxt_s = FETCH;
            if (redirect_i) begin
               pc_nxt_s     = redirect_tgt_s;
               ifid_flush_s = 1'b1;
            end else begin
               ifid_hold_s = 1'b1;
            end
         end
         FETCH: begin
            if (redirect_i) begin
               // An unacked request must still complete; its word is dropped in DRAIN.
               pc_nxt_s     = redirect_tgt_s;
               ifid_flush_s = 1'b1;
               state_nxt_s  = imem_ack_i ? FETCH : DRAIN;
            end else if (imem_ack_i && !hazard_i) begin
               ifid_load_s = 1'b1;
               pc_nxt_s    = pc_r + PC_STEP;
            end else if (imem_ack_i) begin
               ifid_hold_s = 1'b1;
               buf_nxt_s   = imem_rdata_i;
               state_nxt_s = HOLD;
            end else if (hazard_i) begin
               ifid_hold_s = 1'b1;
            end else begin
               ifid_flush_s = 1'b1;
            end
         end
         HOLD: begin
            if (redirect_i) begin
               pc_nxt_s     = redirect_tgt_s;
               ifid_flush_s = 1'b1;
               state_nxt_s  = FETCH;
            end else if (hazard_i) begin
               ifid_hold_s = 1'b1;
            end else begin
               ifid_load_s  = 1'b1;
               ifid_instr_s = buf_r;
               pc_nxt_s     = pc_r + PC_STEP;
               state_nxt_s  = FETCH;
            end
         end
         DRAIN: begin
            ifid_flush_s = 1'b1;
            if (redirect_i) begin
               pc_nxt_s = redirect_tgt_s;
            end else if (imem_ack_i) begin
               state_nxt_s = FETCH;
            end else begin
               state_nxt_s = DRAIN;
            end
         end
         default: begin
            state_nxt_s  = IDLE;
            ifid_flush_s = 1'b1;
         end
      endcase
   end

   // State, PC, skid buffer and registered memory request outputs.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_r <= IDLE;
         pc_r    <= RESET_PC;
         buf_r   <= NOP_INSTR;
         req_r   <= 1'b0;
         addr_r  <= RESET_PC;
      end else begin
         state_r <= state_nxt_s;
         pc_r    <= pc_nxt_s;
         buf_r   <= buf_nxt_s;
         req_r   <= (state_nxt_s == FETCH) || (state_nxt_s == DRAIN);
         addr_r  <= (state_nxt_s == DRAIN) ? addr_r : pc_nxt_s;
      end
   end

   assign imem_req_o  = req_r;
   assign imem_addr_o = addr_r;

   if_id_reg #(
      .XLEN      (XLEN),
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .flush_i (ifid_flush_s),
      .hold_i  (ifid_hold_s),
      .load_i  (ifid_load_s),
      .pc_i    (pc_r),
      .instr_i (ifid_instr_s),
      .valid_o (if_id_valid_o),
      .pc_o    (if_id_pc_o),
      .pc4_o   (if_id_pc4_o),
      .instr_o (if_id_instr_o)
   );

endmodule
